serv_lsu_ctrl: RTL and testbench
================================

SERV_LSU_CTRL -- requirements
Module: serv_lsu_ctrl

Interface
REQ-001 SHALL have parameter W, default 1, meaning bits processed per cycle; legal values are 1 and 4.
REQ-002 SHALL have parameter ALIGN_TRAP, default 1, meaning misaligned accesses are trapped and not issued.
REQ-003 SHALL have port i_clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst  in  1  the reset; synchronous, active-high.
REQ-005 SHALL have port i_req  in  1  start a load/store; sampled only in IDLE.
REQ-006 SHALL have port i_we  in  1  1 = store, 0 = load; latched with i_req.
REQ-007 SHALL have port i_size  in  2  access size (00 byte, 01 half, 10 word; 11 treated as word); latched with i_req.
REQ-008 SHALL have port i_lsb  in  2  address bits [1:0] from the buffer register.
REQ-009 SHALL have port i_dbus_ack  in  1  data bus acknowledge.
REQ-010 SHALL have ports o_buf_en, o_buf_init, o_buf_cnt0, o_buf_cnt1, o_rs1_en, o_imm_en  out  1 each  buffer-register sequencing controls.
REQ-011 SHALL have ports o_dbus_cyc, o_dbus_we  out  1 each, and o_dbus_sel  out  4  data bus request, direction and byte lanes.
REQ-012 SHALL have ports o_busy  out  1; o_done  out  1 (one-cycle completion pulse); o_misalign  out  1 (valid with o_done).

Function
REQ-013 SHALL implement states IDLE, INIT, CHECK, BUS and DONE.
REQ-014 In IDLE all outputs SHALL be 0; i_req=1 SHALL latch i_we and i_size and move to INIT on the next edge.
REQ-015 INIT SHALL last exactly 32/W cycles, tracked by a 5-bit bit counter that starts at 0 and advances by W per cycle.
REQ-016 In INIT, o_buf_en, o_buf_init, o_rs1_en and o_imm_en SHALL be 1.
REQ-017 In INIT, o_buf_cnt0 SHALL be 1 only when counter=0, and o_buf_cnt1 SHALL be 1 only when counter=1 (never asserted for W=4).
REQ-018 When counter=32-W in INIT, the next state SHALL be CHECK, and the counter SHALL wrap to 0.
REQ-019 CHECK SHALL last 1 cycle and set misalign = ALIGN_TRAP & ((half & i_lsb[0]) | (word & |i_lsb)).
REQ-020 From CHECK, a misaligned access SHALL go to DONE; an aligned access SHALL go to BUS.
REQ-021 In BUS, o_dbus_cyc SHALL be 1 and o_dbus_we SHALL equal the latched we; o_busy SHALL be 1 in INIT, CHECK and BUS.
REQ-022 o_dbus_sel SHALL be registered in CHECK and held through BUS.
REQ-023 o_dbus_sel SHALL be 0001<<i_lsb for byte, i_lsb[1] ? 1100 : 0011 for half, and 1111 for word.
REQ-024 BUS SHALL hold until i_dbus_ack=1 while o_dbus_cyc=1; ack in the first BUS cycle SHALL be accepted, so BUS lasts at least 1 cycle.
REQ-025 i_dbus_ack outside BUS SHALL be ignored.
REQ-026 An accepted ack SHALL move the block to DONE, and o_dbus_cyc SHALL be 0 in the following cycle.
REQ-027 DONE SHALL last 1 cycle with o_done=1 and o_misalign=latched misalign, then go to IDLE.
REQ-028 i_req while not in IDLE SHALL be ignored, with no queuing.
REQ-029 i_req in the DONE cycle SHALL be ignored; a new request is accepted from the IDLE cycle onward.
REQ-030 Total latency for an aligned access SHALL be 32/W + 1 + (BUS cycles) + 1 cycles from the i_req edge to o_done.

Reset
REQ-031 i_rst=1 at a rising edge SHALL force IDLE, counter 0, latched we/size/misalign 0 and o_dbus_sel 0, in any state including BUS with cyc asserted.
REQ-032 All outputs SHALL be 0 in the cycle after reset; i_rst SHALL dominate a simultaneous i_req or i_dbus_ack.

Structure
REQ-033 Package serv_lsu_pkg SHALL hold the state encoding and the size constants SIZE_B, SIZE_H and SIZE_W.
REQ-034 Sub-module serv_lsu_sel SHALL be the combinational size/lsb-to-byte-select decoder, instantiated once.
REQ-035 The total RTL SHALL be 120-400 lines.

Verification
REQ-036 Bench SHALL cover: W=1, word load at lsb=00, ack 3 cycles into BUS -> cyc for 3 cycles, sel=1111, we=0, done at cycle 32+1+3+1, misalign=0.
REQ-037 Bench SHALL cover: W=4, byte store at lsb=10, ack same cycle -> INIT 8 cycles, sel=0100, we=1, one BUS cycle, done.
REQ-038 Bench SHALL cover: half access at lsb=01 with ALIGN_TRAP=1 -> no cyc, done+misalign after CHECK.
REQ-039 Bench SHALL cover: the same half access with ALIGN_TRAP=0 -> sel=0011, bus issued.
REQ-040 Bench SHALL cover: i_rst pulsed in BUS cycle 2 -> cyc 0 next cycle, no done, a new i_req afterwards runs normally.
REQ-041 Bench SHALL cover: i_req held high through an operation plus a stray ack in IDLE -> exactly one done, the new request starts only from IDLE, the stray ack has no effect.

Source files
------------

// File: rtl/serv_lsu_pkg.sv
// serv_lsu_pkg: shared definitions for the SERV load/store sequencer.
//   state_t        FSM state encoding (IDLE, INIT, CHECK, BUS, DONE)
//   SIZE_B/H/W     access size codes as carried on i_size (2'b11 behaves as word)
//   is_misaligned  true when the low address bits do not fit the access size
package serv_lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_CHECK = 3'd2,
    ST_BUS   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Halves need bit 0 clear, words need both bits clear; size 2'b11 counts as word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    logic mis;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = lsb[0];
      default: mis = |lsb;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/serv_lsu_ctrl_if.sv
// serv_lsu_ctrl_if: request, buffer-sequencing and data-bus signals of the
// load/store controller.
//   modport slave  : the controller (takes i_*, drives o_*)
//   modport master : the core/bench side (drives i_*, observes o_*)
// Signals:
//   i_req, i_we, i_size[1:0], i_lsb[1:0], i_dbus_ack          requests and bus ack
//   o_buf_en, o_buf_init, o_buf_cnt0, o_buf_cnt1,
//   o_rs1_en, o_imm_en                                        buffer sequencing
//   o_dbus_cyc, o_dbus_we, o_dbus_sel[3:0]                    data bus request
//   o_busy, o_done, o_misalign                                status
interface serv_lsu_ctrl_if;
  logic       i_req;
  logic       i_we;
  logic [1:0] i_size;
  logic [1:0] i_lsb;
  logic       i_dbus_ack;
  logic       o_buf_en;
  logic       o_buf_init;
  logic       o_buf_cnt0;
  logic       o_buf_cnt1;
  logic       o_rs1_en;
  logic       o_imm_en;
  logic       o_dbus_cyc;
  logic       o_dbus_we;
  logic [3:0] o_dbus_sel;
  logic       o_busy;
  logic       o_done;
  logic       o_misalign;

  modport slave (
    input  i_req, i_we, i_size, i_lsb, i_dbus_ack,
    output o_buf_en, o_buf_init, o_buf_cnt0, o_buf_cnt1, o_rs1_en, o_imm_en,
    output o_dbus_cyc, o_dbus_we, o_dbus_sel,
    output o_busy, o_done, o_misalign
  );

  modport master (
    output i_req, i_we, i_size, i_lsb, i_dbus_ack,
    input  o_buf_en, o_buf_init, o_buf_cnt0, o_buf_cnt1, o_rs1_en, o_imm_en,
    input  o_dbus_cyc, o_dbus_we, o_dbus_sel,
    input  o_busy, o_done, o_misalign
  );
endinterface

// File: rtl/serv_lsu_sel.sv
// serv_lsu_sel: combinational byte-lane decoder.
//   size[1:0] in  access size (byte/half/word, 2'b11 as word)
//   lsb[1:0]  in  address bits [1:0]
//   sel[3:0]  out byte-lane enables for the data bus
// A misaligned half (lsb=01/11) still lands on the half chosen by lsb[1].
module serv_lsu_sel
  import serv_lsu_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] lsb,
  output logic [3:0] sel
);

  always_comb begin
    sel = 4'b1111;
    case (size)
      SIZE_B:  sel = 4'b0001 << lsb;
      SIZE_H:  sel = lsb[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  sel = 4'b1111;
      default: sel = 4'b1111;
    endcase
  end

endmodule

// File: rtl/serv_lsu_ctrl.sv
// serv_lsu_ctrl: load/store sequencer for a bit-serial (W=1) or nibble (W=4) core.
// An accepted request first shifts the address through the buffer register
// (INIT, 32/W cycles), checks alignment for one cycle (CHECK), then either
// drives the data bus until acknowledged (BUS) or reports a misalignment trap,
// and finishes with a one-cycle o_done pulse (DONE).
// Parameters:
//   W          bits processed per cycle (1 or 4)
//   ALIGN_TRAP 1 = misaligned accesses trap instead of issuing on the bus
// Ports:
//   i_clk  in  clock, all state changes on the rising edge
//   i_rst  in  synchronous active-high reset
//   lsu    slave modport of serv_lsu_ctrl_if (request in, sequencing/bus/status out)
module serv_lsu_ctrl
  import serv_lsu_pkg::*;
#(
  parameter int W          = 1,
  parameter bit ALIGN_TRAP = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  serv_lsu_ctrl_if.slave lsu
);

  localparam logic [4:0] STEP = 5'(W);
  localparam logic [4:0] LAST = 5'(32 - W);

  state_t     state;
  state_t     state_nxt;
  logic [4:0] cnt;
  logic       we_q;
  logic [1:0] size_q;
  logic       mis_q;
  logic [3:0] sel_q;
  logic [3:0] sel_dec;
  logic       mis_now;

  serv_lsu_sel u_sel (
    .size (size_q),
    .lsb  (lsu.i_lsb),
    .sel  (sel_dec)
  );

  assign mis_now = ALIGN_TRAP ? is_misaligned(size_q, lsu.i_lsb) : 1'b0;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (lsu.i_req) state_nxt = ST_INIT;
      ST_INIT:  if (cnt == LAST) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = mis_now ? ST_DONE : ST_BUS;
      ST_BUS:   if (lsu.i_dbus_ack) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Request context, bit counter and registered byte lanes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt    <= 5'd0;
      we_q   <= 1'b0;
      size_q <= SIZE_B;
      mis_q  <= 1'b0;
      sel_q  <= 4'b0000;
    end else begin
      if (state == ST_IDLE && lsu.i_req) begin
        we_q   <= lsu.i_we;
        size_q <= lsu.i_size;
      end
      // Last INIT step (32-W) wraps the 5-bit counter back to 0 for the next access.
      if (state == ST_INIT) cnt <= cnt + STEP;
      if (state == ST_CHECK) begin
        mis_q <= mis_now;
        sel_q <= sel_dec;
      end
      if (state == ST_DONE) sel_q <= 4'b0000;
    end
  end

  // Outputs decoded from the current state
  always_comb begin
    lsu.o_buf_en   = 1'b0;
    lsu.o_buf_init = 1'b0;
    lsu.o_buf_cnt0 = 1'b0;
    lsu.o_buf_cnt1 = 1'b0;
    lsu.o_rs1_en   = 1'b0;
    lsu.o_imm_en   = 1'b0;
    lsu.o_dbus_cyc = 1'b0;
    lsu.o_dbus_we  = 1'b0;
    lsu.o_dbus_sel = 4'b0000;
    lsu.o_busy     = 1'b0;
    lsu.o_done     = 1'b0;
    lsu.o_misalign = 1'b0;
    case (state)
      ST_INIT: begin
        lsu.o_buf_en   = 1'b1;
        lsu.o_buf_init = 1'b1;
        lsu.o_rs1_en   = 1'b1;
        lsu.o_imm_en   = 1'b1;
        lsu.o_busy     = 1'b1;
        // With W=4 the counter only visits multiples of 4, so cnt1 never fires.
        lsu.o_buf_cnt0 = (cnt == 5'd0);
        lsu.o_buf_cnt1 = (cnt == 5'd1);
      end
      ST_CHECK: lsu.o_busy = 1'b1;
      ST_BUS: begin
        lsu.o_dbus_cyc = 1'b1;
        lsu.o_dbus_we  = we_q;
        lsu.o_dbus_sel = sel_q;
        lsu.o_busy     = 1'b1;
      end
      ST_DONE: begin
        lsu.o_done     = 1'b1;
        lsu.o_misalign = mis_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serv_lsu_ctrl.sv
// tb_serv_lsu_ctrl: bench for serv_lsu_ctrl. Three instances share one set of
// inputs: u_w1 (W=1, trap on), u_w4 (W=4, trap on), u_w4n (W=4, trap off).
// Each instance has a reference model tracking elapsed cycles of the current
// access; directed scenarios are followed by a randomized phase.
module tb_serv_lsu_ctrl;
  import serv_lsu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       we = 1'b0;
  logic       ack = 1'b0;
  logic [1:0] size = 2'b00;
  logic [1:0] lsb = 2'b00;

  always #5 clk = ~clk;

  serv_lsu_ctrl_if if0 ();
  serv_lsu_ctrl_if if1 ();
  serv_lsu_ctrl_if if2 ();

  assign if0.i_req = req;  assign if0.i_we = we;  assign if0.i_size = size;
  assign if0.i_lsb = lsb;  assign if0.i_dbus_ack = ack;
  assign if1.i_req = req;  assign if1.i_we = we;  assign if1.i_size = size;
  assign if1.i_lsb = lsb;  assign if1.i_dbus_ack = ack;
  assign if2.i_req = req;  assign if2.i_we = we;  assign if2.i_size = size;
  assign if2.i_lsb = lsb;  assign if2.i_dbus_ack = ack;

  serv_lsu_ctrl #(.W(1), .ALIGN_TRAP(1'b1)) u_w1  (.i_clk(clk), .i_rst(rst), .lsu(if0));
  serv_lsu_ctrl #(.W(4), .ALIGN_TRAP(1'b1)) u_w4  (.i_clk(clk), .i_rst(rst), .lsu(if1));
  serv_lsu_ctrl #(.W(4), .ALIGN_TRAP(1'b0)) u_w4n (.i_clk(clk), .i_rst(rst), .lsu(if2));

  // Packed view: {buf_en, buf_init, cnt0, cnt1, rs1_en, imm_en, cyc, we, sel[3:0], busy, done, misalign}
  logic [14:0] obs [3];
  assign obs[0] = {if0.o_buf_en, if0.o_buf_init, if0.o_buf_cnt0, if0.o_buf_cnt1, if0.o_rs1_en,
                   if0.o_imm_en, if0.o_dbus_cyc, if0.o_dbus_we, if0.o_dbus_sel, if0.o_busy,
                   if0.o_done, if0.o_misalign};
  assign obs[1] = {if1.o_buf_en, if1.o_buf_init, if1.o_buf_cnt0, if1.o_buf_cnt1, if1.o_rs1_en,
                   if1.o_imm_en, if1.o_dbus_cyc, if1.o_dbus_we, if1.o_dbus_sel, if1.o_busy,
                   if1.o_done, if1.o_misalign};
  assign obs[2] = {if2.o_buf_en, if2.o_buf_init, if2.o_buf_cnt0, if2.o_buf_cnt1, if2.o_rs1_en,
                   if2.o_imm_en, if2.o_dbus_cyc, if2.o_dbus_we, if2.o_dbus_sel, if2.o_busy,
                   if2.o_done, if2.o_misalign};

  int n_checks = 0;
  int n_errors = 0;
  int cyc_no = 0;
  int start_at = 0;

  // Reference model: m_t counts cycles since the request was accepted.
  bit         m_act [3];
  bit         m_fin [3];
  int         m_t   [3];
  bit         m_we  [3];
  logic [1:0] m_size[3];
  bit         m_mis [3];
  logic [3:0] m_sel [3];

  // Observation statistics
  int         cyc_cnt [3];
  int         init_cnt[3];
  int         done_cnt[3];
  int         mis_cnt [3];
  int         done_at [3];
  logic [3:0] last_sel[3];
  logic       last_we [3];

  function automatic int w_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic bit trap_of(input int i);
    return (i != 2);
  endfunction

  function automatic int bytes_of(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Lanes start at the address rounded down to the access size.
  function automatic logic [3:0] ref_sel(input logic [1:0] sz, input logic [1:0] a);
    int b;
    int start;
    b = bytes_of(sz);
    start = int'(a) - (int'(a) % b);
    return 4'(((1 << b) - 1) << start);
  endfunction

  function automatic bit in_bus(input int i);
    return m_act[i] && !m_fin[i] && (m_t[i] >= 32 / w_of(i) + 2);
  endfunction

  function automatic int bus_no(input int i);
    return m_t[i] - 32 / w_of(i) - 1;
  endfunction

  function automatic logic [14:0] exp_out(input int i);
    logic [14:0] e;
    int n;
    int bp;
    e = '0;
    n = 32 / w_of(i);
    if (!m_act[i]) return e;
    if (m_fin[i]) begin
      e[1] = 1'b1;
      e[0] = m_mis[i];
    end else if (m_t[i] <= n) begin
      bp = ((m_t[i] - 1) * w_of(i)) % 32;
      e[14] = 1'b1; e[13] = 1'b1; e[10] = 1'b1; e[9] = 1'b1; e[2] = 1'b1;
      e[12] = (bp == 0);
      e[11] = (bp == 1);
    end else if (m_t[i] == n + 1) begin
      e[2] = 1'b1;
    end else begin
      e[8] = 1'b1;
      e[7] = m_we[i];
      e[6:3] = m_sel[i];
      e[2] = 1'b1;
    end
    return e;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc_no, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented this cycle.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int n;
      n = 32 / w_of(i);
      if (rst) begin
        m_act[i] = 1'b0; m_fin[i] = 1'b0; m_t[i] = 0;
      end else if (!m_act[i]) begin
        if (req) begin
          m_act[i] = 1'b1; m_fin[i] = 1'b0; m_t[i] = 1;
          m_we[i] = we; m_size[i] = size;
        end
      end else if (m_fin[i]) begin
        m_act[i] = 1'b0; m_fin[i] = 1'b0;
      end else if (m_t[i] <= n) begin
        m_t[i]++;
      end else if (m_t[i] == n + 1) begin
        m_sel[i] = ref_sel(m_size[i], lsb);
        m_mis[i] = trap_of(i) && ((int'(lsb) % bytes_of(m_size[i])) != 0);
        if (m_mis[i]) m_fin[i] = 1'b1;
        else m_t[i]++;
      end else begin
        if (ack) m_fin[i] = 1'b1;
        else m_t[i]++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc_no++;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("out_u%0d", i), 32'(obs[i]), 32'(exp_out(i)));
      if (obs[i][8]) begin
        cyc_cnt[i]++;
        last_sel[i] = obs[i][6:3];
        last_we[i] = obs[i][7];
      end
      if (obs[i][14]) init_cnt[i]++;
      if (obs[i][1]) begin
        done_cnt[i]++;
        done_at[i] = cyc_no;
        if (obs[i][0]) mis_cnt[i]++;
      end
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 3; i++) begin
      cyc_cnt[i] = 0; init_cnt[i] = 0; done_cnt[i] = 0; mis_cnt[i] = 0;
      done_at[i] = -1; last_sel[i] = 4'h0; last_we[i] = 1'b0;
    end
  endtask

  task automatic wait_bus(input int i, input int k);
    int guard;
    guard = 0;
    while (!(in_bus(i) && bus_no(i) == k) && guard < 200) begin
      tick();
      guard++;
    end
    check_val($sformatf("reach_bus_u%0d", i), 32'(guard < 200), 32'd1);
  endtask

  task automatic wait_done(input int i);
    int guard;
    guard = 0;
    while (!obs[i][1] && guard < 200) begin
      tick();
      guard++;
    end
    check_val($sformatf("reach_done_u%0d", i), 32'(guard < 200), 32'd1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    req = 1'b0;
    ack = 1'b1;
    while ((m_act[0] || m_act[1] || m_act[2]) && guard < 300) begin
      tick();
      guard++;
    end
    ack = 1'b0;
    check_val("drain_idle", 32'(m_act[0] || m_act[1] || m_act[2]), 32'd0);
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic [1:0] a);
    we = w; size = sz; lsb = a; req = 1'b1;
    start_at = cyc_no;
    tick();
    req = 1'b0;
  endtask

  initial begin
    clear_stats();
    // Reset dominates a simultaneous request and ack
    rst = 1'b1; req = 1'b1; ack = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) check_val($sformatf("rst_out_u%0d", i), 32'(obs[i]), 32'd0);
    req = 1'b0; ack = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // W=1 word load at lsb=00, ack in the third BUS cycle
    clear_stats();
    issue(1'b0, SIZE_W, 2'b00);
    wait_bus(0, 3);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_val("a_cyc_cycles", 32'(cyc_cnt[0]), 32'd3);
    check_val("a_sel", 32'(last_sel[0]), 32'hF);
    check_val("a_we", 32'(last_we[0]), 32'd0);
    check_val("a_latency", 32'(done_at[0] - start_at), 32'(32 + 1 + 3 + 1));
    check_val("a_misalign", 32'(mis_cnt[0]), 32'd0);
    check_val("a_init_cycles", 32'(init_cnt[0]), 32'd32);
    drain();

    // W=4 byte store at lsb=10, ack in the first BUS cycle
    clear_stats();
    issue(1'b1, SIZE_B, 2'b10);
    wait_bus(1, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_val("b_init_cycles", 32'(init_cnt[1]), 32'd8);
    check_val("b_sel", 32'(last_sel[1]), 32'h4);
    check_val("b_we", 32'(last_we[1]), 32'd1);
    check_val("b_cyc_cycles", 32'(cyc_cnt[1]), 32'd1);
    check_val("b_done", 32'(done_cnt[1]), 32'd1);
    check_val("b_latency", 32'(done_at[1] - start_at), 32'(8 + 1 + 1 + 1));
    drain();

    // Half at lsb=01: trapped on u_w4, issued with lanes 0011 on u_w4n
    clear_stats();
    issue(1'b0, SIZE_H, 2'b01);
    wait_done(1);
    check_val("c_trap_cyc", 32'(cyc_cnt[1]), 32'd0);
    check_val("c_trap_misalign", 32'(mis_cnt[1]), 32'd1);
    check_val("c_trap_latency", 32'(done_at[1] - start_at), 32'(8 + 1 + 1));
    wait_bus(2, 2);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_val("d_notrap_sel", 32'(last_sel[2]), 32'h3);
    check_val("d_notrap_cyc", 32'(cyc_cnt[2]), 32'd2);
    check_val("d_notrap_misalign", 32'(mis_cnt[2]), 32'd0);
    check_val("d_notrap_done", 32'(done_cnt[2]), 32'd1);
    drain();

    // Reset in the second BUS cycle of u_w1, then a normal access
    clear_stats();
    issue(1'b0, SIZE_W, 2'b00);
    wait_bus(0, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("e_cyc_after_rst", 32'(obs[0][8]), 32'd0);
    check_val("e_out_after_rst", 32'(obs[0]), 32'd0);
    repeat (4) tick();
    check_val("e_no_done", 32'(done_cnt[0]), 32'd0);
    clear_stats();
    issue(1'b1, SIZE_W, 2'b00);
    wait_bus(0, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_val("e_rerun_done", 32'(done_cnt[0]), 32'd1);
    check_val("e_rerun_we", 32'(last_we[0]), 32'd1);
    check_val("e_rerun_latency", 32'(done_at[0] - start_at), 32'(32 + 1 + 1 + 1));
    drain();

    // Stray ack in IDLE, then i_req held through a whole access on u_w4
    clear_stats();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_val("f_stray_ack_u1", 32'(obs[1]), 32'd0);
    check_val("f_stray_ack_u0", 32'(obs[0]), 32'd0);
    we = 1'b0; size = SIZE_W; lsb = 2'b00; req = 1'b1;
    tick();
    wait_bus(1, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_val("f_done_pulse", 32'(obs[1][1]), 32'd1);
    tick();
    check_val("f_idle_gap", 32'(obs[1]), 32'd0);
    check_val("f_one_done", 32'(done_cnt[1]), 32'd1);
    tick();
    check_val("f_restart_init", 32'(obs[1][14]), 32'd1);
    req = 1'b0;
    drain();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      req  = ($urandom_range(0, 3) == 0);
      we   = 1'($urandom);
      size = 2'($urandom);
      lsb  = 2'($urandom);
      ack  = ($urandom_range(0, 2) == 0);
      rst  = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
